// File: rtl/mips_boot_loader_if.sv
// mips_boot_loader_if: byte-stream input, instruction-memory write port and core control outputs of the boot loader
interface mips_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
    );
endinterface

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: streams a length-prefixed, checksummed byte image into instruction memory and holds the core in reset until it verifies
module mips_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MEM_WORDS = 256
) (
    input logic clk,
    input logic rst,
    mips_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              error_q;
    logic [15:0]       len_q;
    logic [15:0]       cnt_q;
    logic [1:0]        byte_q;
    logic [23:0]       asm_q;
    logic [7:0]        csum_q;
    logic              xfer;
    logic [15:0]       n_len;

    assign xfer  = bus.in_valid && in_ready_q;
    assign n_len = {len_q[15:8], bus.in_data};

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

    // Frame parser: length, word assembly with checksum, final checksum compare; outputs all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LEN_HI;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            byte_q       <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                LEN_HI: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        len_q[15:8] <= bus.in_data;
                        state_q     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q <= n_len;
                        if (n_len > 16'(MEM_WORDS)) begin
                            state_q    <= ERROR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= (n_len == 16'd0) ? CSUM : DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ bus.in_data;
                        asm_q  <= {asm_q[15:0], bus.in_data};
                        byte_q <= byte_q + 2'd1;
                        if (byte_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= cnt_q[ADDR_W-1:0];
                            imem_wdata_q <= {asm_q, bus.in_data};
                            cnt_q        <= cnt_q + 16'd1;
                            if (cnt_q == len_q - 16'd1)
                                state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_data == csum_q) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: in_ready_q <= 1'b0;
            endcase
        end
    end
endmodule
